// File: rtl/glb_arb_pkg.sv
// glb_arb_pkg: shared state encoding and stream width for the GLB write-stream arbiter.
package glb_arb_pkg;
    typedef enum logic [1:0] {IDLE, ARB, BURST, DONE} arb_state_t;
    localparam int GLB_DATA_W = 17;
endpackage

// File: rtl/glb_stream_arbiter_if.sv
// glb_stream_arbiter_if: source-side and output-side stream handshakes of the arbiter.
// master = the arbiter, slave = the write sources plus the downstream consumer.
interface glb_stream_arbiter_if
    import glb_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = GLB_DATA_W
);
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_done;
    logic [DATA_W-1:0]         out_data;
    logic                      out_valid;
    logic                      out_ready;

    modport master (
        input  req_data, req_valid, req_done, out_ready,
        output req_ready, out_data, out_valid
    );
    modport slave (
        output req_data, req_valid, req_done, out_ready,
        input  req_ready, out_data, out_valid
    );
endinterface

// File: rtl/glb_rr_pick.sv
// glb_rr_pick: combinational round-robin picker; returns the first eligible index
// strictly after rr_ptr, wrapping around.
module glb_rr_pick #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  eligible,
    input  logic [IW-1:0] rr_ptr,
    output logic          found,
    output logic [IW-1:0] idx
);
    logic [IW-1:0] j;

    always_comb begin
        found = 1'b0;
        idx = '0;
        j = '0;
        // scan farthest-first so the nearest eligible index after rr_ptr is the last to win
        for (int k = N; k >= 1; k--) begin
            j = IW'((int'(rr_ptr) + k) % N);
            if (eligible[j]) begin
                found = 1'b1;
                idx = j;
            end
        end
    end
endmodule

// File: rtl/glb_stream_arbiter.sv
// glb_stream_arbiter: round-robin arbiter sharing one GLB->fabric write stream among NUM_REQ sources.
// Define GLB_ARB_STATS_EN to add the per-source saturating beat counters on beat_total.
module glb_stream_arbiter
    import glb_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = GLB_DATA_W,
    parameter int MAX_BURST = 16,
    localparam int IW = $clog2(NUM_REQ),
    localparam int CW = $clog2(MAX_BURST + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    glb_stream_arbiter_if.master   st,
    output logic                   out_done,
    output logic [IW-1:0]          grant_id
`ifdef GLB_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]  beat_total
`endif
);
    arb_state_t         state, nxt;
    logic [IW-1:0]      rr_ptr, pick;
    logic [NUM_REQ-1:0] done_mask, eligible;
    logic [CW-1:0]      beat_cnt;
    logic [DATA_W-1:0]  last_data, g_data;
    logic               found, in_burst, g_valid, g_done, beat, last_beat;

    assign g_data    = DATA_W'(st.req_data >> (DATA_W * grant_id));
    assign g_valid   = st.req_valid[grant_id];
    assign g_done    = st.req_done[grant_id];
    assign in_burst  = state == BURST;
    assign beat      = in_burst && g_valid && st.out_ready;
    assign last_beat = beat && beat_cnt == CW'(MAX_BURST - 1);
    // a source raising done this very cycle is already out of the running
    assign eligible  = st.req_valid & ~done_mask & ~st.req_done;

    glb_rr_pick #(.N(NUM_REQ)) u_pick (
        .eligible (eligible),
        .rr_ptr   (rr_ptr),
        .found    (found),
        .idx      (pick)
    );

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = ARB;
            ARB:     nxt = &done_mask ? DONE : found ? BURST : ARB;
            BURST:   nxt = (last_beat || !g_valid || g_done) ? ARB : BURST;
            default: nxt = DONE;
        endcase
        if (flush) nxt = IDLE;
    end

    assign st.out_valid = in_burst && g_valid;
    assign st.out_data  = in_burst ? g_data : last_data;
    assign st.req_ready = in_burst ? (NUM_REQ'(st.out_ready) << grant_id) : '0;
    assign out_done     = state == DONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant_id  <= '0;
            rr_ptr    <= IW'(NUM_REQ - 1);
            done_mask <= '0;
            beat_cnt  <= '0;
            last_data <= '0;
        end else begin
            state     <= nxt;
            last_data <= st.out_data;
            if (flush) begin
                done_mask <= '0;
                rr_ptr    <= IW'(NUM_REQ - 1);
            end else if (state != IDLE) begin
                done_mask <= done_mask | st.req_done;
            end
            if (state == ARB && nxt == BURST) begin
                grant_id <= pick;
                rr_ptr   <= pick;
                beat_cnt <= '0;
            end else if (beat) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

`ifdef GLB_ARB_STATS_EN
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
        logic [15:0] cnt;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                cnt <= '0;
            else if (flush)
                cnt <= '0;
            else if (beat && grant_id == IW'(i) && cnt != 16'hFFFF)
                cnt <= cnt + 16'd1;
        end
        assign beat_total[i*16 +: 16] = cnt;
    end
`endif
endmodule

// File: tb/tb_glb_stream_arbiter.sv
// tb_glb_stream_arbiter: randomized scoreboard bench; a transaction-level round-robin
// model predicts the beat order, a separate monitor pops and compares every beat.
module tb_glb_stream_arbiter;
    localparam int N = 4;
    localparam int W = 17;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic flush = 1'b0;
    logic out_done;
    logic [1:0] grant_id;
`ifdef GLB_ARB_STATS_EN
    logic [N*16-1:0] beat_total;
`endif

    glb_stream_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) ar ();

    glb_stream_arbiter #(.NUM_REQ(N), .DATA_W(W), .MAX_BURST(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .st       (ar),
        .out_done (out_done),
        .grant_id (grant_id)
`ifdef GLB_ARB_STATS_EN
        ,
        .beat_total (beat_total)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit mon_en = 1'b0;
    bit ordered = 1'b0;
    logic [W-1:0] words [N][64];
    logic [W-1:0] src_q [N][$];
    int ord_q[$];
    int n[N];
    int pos[N];
    bit dol[N];
    int exp_cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name, input string got, input string want);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got %s, expected %s (t=%0t)", name, got, want, $time);
    endtask

    // per-source data order always; global grant order when the model applies
    always @(negedge clk) begin
        if (mon_en) begin
            #2;
            if (ar.out_valid && ar.out_ready) begin
                chk("req_ready_mirror", 32'(ar.req_ready), 32'(1) << grant_id);
                if (src_q[grant_id].size() == 0)
                    fail("beat_data", "beat from a drained source", "no beat");
                else
                    chk("beat_data", 32'(ar.out_data), 32'(src_q[grant_id].pop_front()));
                if (ordered) begin
                    if (ord_q.size() == 0)
                        fail("grant_order", "extra beat", "no beat");
                    else
                        chk("grant_order", 32'(grant_id), 32'(ord_q.pop_front()));
                end
            end
        end
    end

    // round robin from source 0, each grant min(16, remaining) words; cycles = ARB + beats per grant
    task automatic build(input bit all_dol);
        int rem[N];
        int ptr, k, tot;
        bit found;
        tot = 0;
        for (int i = 0; i < N; i++) begin
            n[i] = $urandom_range(0, 40);
            tot += n[i];
        end
        if (tot == 0) n[0] = 1;
        for (int i = 0; i < N; i++) begin
            pos[i] = 0;
            rem[i] = n[i];
            dol[i] = all_dol || ($urandom_range(0, 1) == 1);
            src_q[i].delete();
            for (int j = 0; j < n[i]; j++) begin
                words[i][j] = W'($urandom);
                src_q[i].push_back(words[i][j]);
            end
        end
        ord_q.delete();
        exp_cyc = 2;
        ptr = N - 1;
        while (1) begin
            found = 1'b0;
            for (int o = 1; o <= N; o++) begin
                if (!found && rem[(ptr + o) % N] > 0) begin
                    found = 1'b1;
                    ptr = (ptr + o) % N;
                end
            end
            if (!found) break;
            k = rem[ptr] < 16 ? rem[ptr] : 16;
            rem[ptr] -= k;
            exp_cyc += 1 + k;
            repeat (k) ord_q.push_back(ptr);
        end
    endtask

    task automatic drive(input bit fr, input bit bub);
        logic [W-1:0] dv[N];
        ar.out_ready = fr ? 1'b1 : ($urandom_range(0, 3) != 0);
        for (int i = 0; i < N; i++) begin
            ar.req_valid[2'(i)] = pos[i] < n[i] && (!bub || $urandom_range(0, 3) != 0);
            ar.req_done[2'(i)] = pos[i] >= n[i];
            dv[i] = pos[i] < n[i] ? words[i][pos[i]] : '0;
        end
        ar.req_data = {dv[3], dv[2], dv[1], dv[0]};
        #1;
        // some sources raise done together with their final accepted beat
        for (int i = 0; i < N; i++)
            if (dol[i] && pos[i] == n[i] - 1 && ar.req_ready[2'(i)]) ar.req_done[2'(i)] = 1'b1;
        #1;
        for (int i = 0; i < N; i++)
            if (ar.req_valid[2'(i)] && ar.req_ready[2'(i)]) pos[i]++;
    endtask

    task automatic pulse_flush();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic run(input bit ord, input bit fr, input bit bub, input bit all_dol);
        int c, left;
        bit seen;
        build(all_dol);
        if (!ord) ord_q.delete();
        ordered = ord;
        pulse_flush();
        mon_en = 1'b1;
        c = 0;
        seen = 1'b0;
        while (!seen && c < 4000) begin
            @(negedge clk);
            c++;
            drive(fr, bub);
            seen = out_done;
        end
        mon_en = 1'b0;
        if (!seen)
            fail("done_timeout", "out_done still low", "out_done high");
        else if (ord && fr && all_dol)
            chk("done_cycle", 32'(c), 32'(exp_cyc));
        left = ord_q.size();
        for (int i = 0; i < N; i++) left += src_q[i].size();
        chk("leftover_beats", 32'(left), 32'd0);
`ifdef GLB_ARB_STATS_EN
        for (int i = 0; i < N; i++) chk("beat_total", 32'(beat_total[i*16 +: 16]), 32'(n[i]));
`endif
        repeat (3) @(negedge clk);
        #2;
        chk("done_sticky", 32'(out_done), 32'd1);
        pulse_flush();
        #2;
        chk("flush_clears_done", 32'(out_done), 32'd0);
        chk("flush_idle_valid", 32'(ar.out_valid), 32'd0);
    endtask

    // src0 and src1 both valid: after a flush mid-burst src0 must win again
    task automatic flush_reset_test();
        pulse_flush();
        ar.out_ready = 1'b1;
        ar.req_valid = 4'b0011;
        ar.req_done = 4'b0000;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            ar.req_data = '0;
            ar.req_data[W-1:0] = W'(32'h100 + c);
            ar.req_data[2*W-1:W] = W'(32'h200 + c);
            flush = (c == 8);
            #2;
            if (c == 8) begin
                chk("flush_beat_valid", 32'(ar.out_valid), 32'd1);
                chk("flush_beat_data", 32'(ar.out_data), 32'h108);
            end
            if (c == 9) begin
                chk("flush_drop_valid", 32'(ar.out_valid), 32'd0);
                chk("flush_drop_ready", 32'(ar.req_ready), 32'd0);
            end
            if (c == 11) begin
                chk("post_flush_grant", 32'(grant_id), 32'd0);
                chk("post_flush_data", 32'(ar.out_data), 32'h10B);
            end
        end
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(ar.out_valid), 32'd0);
        chk("rst_mid_ready", 32'(ar.req_ready), 32'd0);
        chk("rst_mid_data", 32'(ar.out_data), 32'd0);
        chk("rst_mid_grant", 32'(grant_id), 32'd0);
`ifdef GLB_ARB_STATS_EN
        chk("rst_mid_stats", 32'(beat_total[15:0]), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ar.req_valid = '0;
        ar.req_done = '0;
        ar.req_data = '0;
        ar.out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #2;
        chk("rst_out_valid", 32'(ar.out_valid), 32'd0);
        chk("rst_req_ready", 32'(ar.req_ready), 32'd0);
        chk("rst_out_data", 32'(ar.out_data), 32'd0);
        chk("rst_out_done", 32'(out_done), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run(1'b1, 1'b1, 1'b0, 1'b1);
        repeat (3) run(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (2) run(1'b0, 1'b0, 1'b1, 1'b0);
        flush_reset_test();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
